// File: rtl/flag_datapath_pkg.sv
// rtl/flag_datapath_pkg.sv - shared widths, ALU opcodes, flag bit indices and B-mux selects
package flag_datapath_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 16;
    localparam int IDX_W    = 4;
    localparam int FLAG_W   = 5;

    // Flag register layout {N,Z,F,L,C}
    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_CMP = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_NOT = 4'd6,
        OP_LSH = 4'd7,
        OP_RSH = 4'd8,
        OP_MOV = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        B_SEL_REG   = 2'd0,
        B_SEL_IMM   = 2'd1,
        B_SEL_FLAGS = 2'd2,
        B_SEL_ZERO  = 2'd3
    } b_sel_e;

endpackage

// File: rtl/flag_datapath_alu_core.sv
// rtl/flag_datapath_alu_core.sv - combinational ALU producing result and {N,Z,F,L,C} flag vector
module flag_datapath_alu_core
    import flag_datapath_pkg::*;
(
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic [FLAG_W-1:0] flags
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    logic            carry;
    logic            ovf;
    logic            less;
    logic            neg;
    logic            zero;

    // Extra top bit gives carry-out for ADD and borrow for SUB/CMP
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        less   = 1'b0;
        case (opcode)
            OP_ADD: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
                ovf    = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
                result = diff[DATA_W-1:0];
                carry  = diff[DATA_W];
                less   = diff[DATA_W];
                ovf    = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            end
            OP_CMP: begin
                result = diff[DATA_W-1:0];
                less   = diff[DATA_W];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_LSH: result = a << b[3:0];
            OP_RSH: result = a >> b[3:0];
            OP_MOV: result = b;
            default: result = '0;
        endcase
    end

    // CMP reports a signed ordering in N and equality in Z rather than result sign/zero
    always_comb begin
        neg  = result[DATA_W-1];
        zero = (result == '0);
        if (opcode == OP_CMP) begin
            neg  = $signed(a) < $signed(b);
            zero = (a == b);
        end
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_N] = neg;
        flags[FLAG_Z] = zero;
        flags[FLAG_F] = ovf;
        flags[FLAG_L] = less;
        flags[FLAG_C] = carry;
    end

endmodule

// File: rtl/flag_datapath.sv
// rtl/flag_datapath.sv - 16x16 register file, B-operand mux, ALU and flag register
module flag_datapath
    import flag_datapath_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REGS-1:0] reg_en,
    input  logic [IDX_W-1:0]    reg_a,
    input  logic [IDX_W-1:0]    reg_b,
    input  logic [DATA_W-1:0]   imm,
    input  logic [1:0]          b_sel,
    input  logic [3:0]          opcode,
    input  logic                flag_en,
    output logic [DATA_W-1:0]   alu_out,
    output logic [FLAG_W-1:0]   flags
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [FLAG_W-1:0] flag_q;
    logic [FLAG_W-1:0] alu_flags;
    logic [DATA_W-1:0] a_opnd;
    logic [DATA_W-1:0] b_opnd;

    assign a_opnd = regs[reg_a];

    // Flags word reads the registered value, so a same-cycle flag_en sees the old flags
    always_comb begin
        b_opnd = '0;
        case (b_sel)
            B_SEL_REG:   b_opnd = regs[reg_b];
            B_SEL_IMM:   b_opnd = imm;
            B_SEL_FLAGS: b_opnd = {{(DATA_W-FLAG_W){1'b0}}, flag_q};
            default:     b_opnd = '0;
        endcase
    end

    flag_datapath_alu_core u_alu_core (
        .opcode (opcode),
        .a      (a_opnd),
        .b      (b_opnd),
        .result (alu_out),
        .flags  (alu_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_en[i]) begin
                    regs[i] <= alu_out;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= '0;
        end else if (flag_en) begin
            flag_q <= alu_flags;
        end
    end

    assign flags = flag_q;

endmodule

// File: tb/tb_flag_datapath.sv
// tb/tb_flag_datapath.sv - randomized scoreboard bench for flag_datapath against an arithmetic reference model
module tb_flag_datapath;
    import flag_datapath_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] reg_en = '0;
    logic [3:0]  reg_a = '0;
    logic [3:0]  reg_b = '0;
    logic [15:0] imm = '0;
    logic [1:0]  b_sel = '0;
    logic [3:0]  opcode = '0;
    logic        flag_en = 1'b0;
    logic [15:0] alu_out;
    logic [4:0]  flags;

    flag_datapath dut (
        .clk     (clk),
        .rst     (rst),
        .reg_en  (reg_en),
        .reg_a   (reg_a),
        .reg_b   (reg_b),
        .imm     (imm),
        .b_sel   (b_sel),
        .opcode  (opcode),
        .flag_en (flag_en),
        .alu_out (alu_out),
        .flags   (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] alu;
        logic [4:0]  flg;
        int          id;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          next_id = 0;
    logic [15:0] m_r [16];
    logic [4:0]  m_f;

    function automatic void ref_alu(input int op, input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] res, output logic [4:0] f);
        int ua = a;
        int ub = b;
        int sa = $signed(a);
        int sbv = $signed(b);
        int wide = 0;
        bit c = 0, v = 0, l = 0, n, z;
        res = 16'h0000;
        case (op)
            OP_ADD: begin wide = ua + ub; res = wide[15:0]; c = (wide > 65535);
                          v = (sa + sbv > 32767) || (sa + sbv < -32768); end
            OP_SUB: begin wide = ua - ub; res = wide[15:0]; c = (ua < ub); l = (ua < ub);
                          v = (sa - sbv > 32767) || (sa - sbv < -32768); end
            OP_CMP: begin wide = ua - ub; res = wide[15:0]; l = (ua < ub); end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOT: res = ~a;
            OP_LSH: begin wide = ua * (1 << (ub % 16)); res = wide[15:0]; end
            OP_RSH: begin wide = ua / (1 << (ub % 16)); res = wide[15:0]; end
            OP_MOV: res = b;
            default: res = 16'h0000;
        endcase
        n = res[15];
        z = (res == 16'h0000);
        if (op == OP_CMP) begin
            n = (sa < sbv);
            z = (ua == ub);
        end
        f = {n, z, v, l, c};
    endfunction

    task automatic step(input logic [15:0] en, input int ra, input int rb, input logic [15:0] im,
                        input int bs, input int op, input bit fe);
        logic [15:0] bval, res;
        logic [4:0]  f;
        exp_t        e;
        @(negedge clk);
        reg_en = en; reg_a = ra[3:0]; reg_b = rb[3:0]; imm = im;
        b_sel = bs[1:0]; opcode = op[3:0]; flag_en = fe;
        case (bs)
            0: bval = m_r[rb];
            1: bval = im;
            2: bval = {11'b0, m_f};
            default: bval = 16'h0000;
        endcase
        ref_alu(op, m_r[ra], bval, res, f);
        e.alu = res; e.flg = m_f; e.id = next_id++;
        sb.push_back(e);
        for (int i = 0; i < 16; i++) if (en[i]) m_r[i] = res;
        if (fe) m_f = f;
    endtask

    // Reset arrives after the drive point; hold=1 keeps it asserted across a posedge with writes pending
    task automatic async_reset(input bit hold);
        exp_t e;
        @(negedge clk);
        reg_en = hold ? 16'hffff : 16'h0000; flag_en = hold;
        reg_a = 4'd1; reg_b = 4'd2; imm = 16'hbeef; b_sel = 2'd0; opcode = OP_ADD;
        e.alu = 16'h0000; e.flg = 5'h00; e.id = next_id++;
        sb.push_back(e);
        #1 rst = 1'b1;
        if (hold) begin
            @(posedge clk);
            #2;
        end else begin
            #2;
        end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) m_r[i] = 16'h0000;
        m_f = 5'h00;
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) step(16'h0000, 0, i, 16'h0000, 0, OP_MOV, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (alu_out !== e.alu) begin
                    miscompares++;
                    $display("FAIL vec%0d alu_out: got %h expected %h", e.id, alu_out, e.alu);
                end
                if (flags !== e.flg) begin
                    miscompares++;
                    $display("FAIL vec%0d flags: got %h expected %h", e.id, flags, e.flg);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not reach summary, got timeout expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        for (int i = 0; i < 16; i++) m_r[i] = 16'h0000;
        m_f = 5'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        read_all();
        step(16'h0002, 0, 0, 16'h7fff, 1, OP_ADD, 0);
        step(16'h0004, 0, 0, 16'hffff, 1, OP_ADD, 0);
        step(16'h0008, 0, 0, 16'h8000, 1, OP_ADD, 0);
        for (int i = 1; i <= 3; i++) step(16'h0000, 0, i, 16'h0000, 0, OP_MOV, 0);

        step(16'h0000, 1, 2, 16'h0000, 0, OP_ADD, 1);
        step(16'h0010, 0, 0, 16'h0000, 2, OP_MOV, 0);
        step(16'h0000, 3, 1, 16'h0000, 0, OP_SUB, 1);
        step(16'h0020, 0, 0, 16'h0000, 2, OP_MOV, 0);
        step(16'h0000, 3, 2, 16'h0000, 0, OP_CMP, 1);
        step(16'h0040, 0, 0, 16'h0000, 2, OP_MOV, 0);
        step(16'h0000, 0, 2, 16'h0000, 0, OP_ADD, 1);
        step(16'h0080, 0, 0, 16'h0000, 2, OP_MOV, 1);
        step(16'h0000, 2, 2, 16'h0000, 0, OP_SUB, 1);
        step(16'h0100, 0, 0, 16'h0000, 2, OP_MOV, 0);
        step(16'h1000, 4, 5, 16'h0000, 0, OP_OR, 0);
        for (int i = 6; i <= 8; i++) step(16'h1000, 12, i, 16'h0000, 0, OP_OR, 0);
        step(16'h8000, 0, 12, 16'h0000, 0, OP_MOV, 0);
        step(16'h0000, 0, 15, 16'h0000, 0, OP_ADD, 0);

        step(16'h0006, 0, 0, 16'h1234, 1, OP_MOV, 0);
        step(16'h0000, 1, 2, 16'h0000, 0, OP_XOR, 0);

        async_reset(1'b0);
        read_all();
        step(16'h0002, 0, 0, 16'h0001, 1, OP_ADD, 0);
        step(16'h0000, 1, 0, 16'h000f, 1, OP_LSH, 1);
        step(16'h0000, 1, 0, 16'h0010, 1, OP_LSH, 0);
        async_reset(1'b1);
        read_all();

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                async_reset($urandom_range(0, 1) == 1);
            end else begin
                step(16'($urandom & $urandom & $urandom), $urandom_range(0, 15), $urandom_range(0, 15),
                     16'($urandom), $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 1) == 1);
            end
        end
        read_all();

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
